// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program-image loader: FSM states, memory geometry,
// end-of-program marker and RAM control levels.
package prog_loader_pkg;

  localparam int unsigned RAM_ADDR_W     = 11;
  localparam int unsigned RAM_DEPTH      = 2048;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = 4;

  // Word that terminates an image; it is written to memory like any other word.
  localparam logic [WORD_W-1:0] HALT_WORD = 32'hFFFF_FFFF;

  // RAM2Kx32 control pins are active-low.
  localparam logic RAM_EN_ON  = 1'b0;
  localparam logic RAM_EN_OFF = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_WRITE,
    ST_DONE,
    ST_ERROR
  } state_e;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Packs accepted host bytes big-endian into a 32-bit word; the first byte of a
// word ends up in [31:24]. word_c/word_valid_c present the completed word in the
// same cycle the fourth byte is accepted so the FSM can register it directly.
module prog_loader_byte_packer
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              accept,
  input  logic [BYTE_W-1:0] in_byte,
  output logic [WORD_W-1:0] word_c,
  output logic              word_valid_c
);

  logic [1:0]        byte_idx;
  logic [WORD_W-1:0] shift_q;

  // Byte index wraps 3 -> 0 on its own, so no explicit end-of-word reset is needed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx <= 2'd0;
      shift_q  <= '0;
    end else if (clear) begin
      byte_idx <= 2'd0;
      shift_q  <= '0;
    end else if (accept) begin
      byte_idx <= byte_idx + 2'd1;
      shift_q  <= word_c;
    end
  end

  assign word_c       = {shift_q[WORD_W-BYTE_W-1:0], in_byte};
  assign word_valid_c = accept && (byte_idx == 2'd3);

endmodule

// File: rtl/prog_loader.sv
// Streams a host byte image into the 2Kx32 instruction RAM and releases the
// processor from reset once the HALT word has been written.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = RAM_ADDR_W,
  parameter int unsigned DATA_WIDTH = WORD_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [BYTE_W-1:0]     in_byte,
  output logic                  in_ready,
  output logic                  mem_cen,
  output logic                  mem_wen,
  output logic                  mem_oen,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  cpu_reset_n,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);

  state_e            state;
  logic              load_start_c;
  logic              accept_c;
  logic [WORD_W-1:0] word_c;
  logic              word_valid_c;

  // start only counts while no load is running.
  assign load_start_c = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));
  // in_ready is only ever high in COLLECT, so this is the whole byte handshake.
  assign accept_c     = in_valid && in_ready;

  prog_loader_byte_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clear        (load_start_c),
    .accept       (accept_c),
    .in_byte      (in_byte),
    .word_c       (word_c),
    .word_valid_c (word_valid_c)
  );

  // Loader FSM with all outputs registered; the address counter doubles as mem_addr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      in_ready    <= 1'b0;
      mem_cen     <= RAM_EN_OFF;
      mem_wen     <= RAM_EN_OFF;
      mem_oen     <= RAM_EN_OFF;
      mem_addr    <= '0;
      mem_data    <= '0;
      cpu_reset_n <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      word_count  <= '0;
    end else begin
      mem_oen <= RAM_EN_OFF;
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (load_start_c) begin
            state       <= ST_COLLECT;
            in_ready    <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b0;
            error       <= 1'b0;
            cpu_reset_n <= 1'b0;
            mem_cen     <= RAM_EN_OFF;
            mem_wen     <= RAM_EN_OFF;
            mem_addr    <= '0;
            word_count  <= '0;
          end
        end
        ST_COLLECT: begin
          if (word_valid_c) begin
            state    <= ST_WRITE;
            in_ready <= 1'b0;
            mem_cen  <= RAM_EN_ON;
            mem_wen  <= RAM_EN_ON;
            mem_data <= DATA_WIDTH'(word_c);
          end
        end
        ST_WRITE: begin
          mem_cen    <= RAM_EN_OFF;
          mem_wen    <= RAM_EN_OFF;
          word_count <= word_count + CNT_ONE;
          // The top address is never stepped past, so a full RAM leaves mem_addr at 2047.
          if (mem_addr != LAST_ADDR) begin
            mem_addr <= mem_addr + ADDR_ONE;
          end
          if (mem_data == DATA_WIDTH'(HALT_WORD)) begin
            state       <= ST_DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            cpu_reset_n <= 1'b1;
          end else if (mem_addr == LAST_ADDR) begin
            state <= ST_ERROR;
            busy  <= 1'b0;
            error <= 1'b1;
          end else begin
            state    <= ST_COLLECT;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomised scoreboard bench for prog_loader: the driver queues each expected
// RAM write as it hands over a word's fourth byte, and a monitor on the RAM
// port pops and compares every write the loader performs.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        mem_cen;
  logic        mem_wen;
  logic        mem_oen;
  logic [10:0] mem_addr;
  logic [31:0] mem_data;
  logic        cpu_reset_n;
  logic        busy;
  logic        done;
  logic        error;
  logic [11:0] word_count;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [10:0] addr;
    logic [31:0] data;
  } wr_t;

  int          total = 0;
  int          bad   = 0;
  wr_t         exp_q[$];
  logic [31:0] ref_ram[2048];
  logic [31:0] tb_ram[2048];
  int          ref_count;
  bit          ref_done;
  logic        wen_prev = 1'b1;

  prog_loader dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_valid    (in_valid),
    .in_byte     (in_byte),
    .in_ready    (in_ready),
    .mem_cen     (mem_cen),
    .mem_wen     (mem_wen),
    .mem_oen     (mem_oen),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .cpu_reset_n (cpu_reset_n),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .word_count  (word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // RAM-side monitor: every write cycle must match the oldest expected word.
  always @(negedge clk) begin
    wr_t e;
    if (!rst && mem_wen == 1'b0) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_write: addr 0x%0h data 0x%0h, expected no write", mem_addr, mem_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(mem_addr), 64'(e.addr));
        chk("wr_data", 64'(mem_data), 64'(e.data));
        chk("wr_cen", 64'(mem_cen), 64'd0);
        chk("wr_oen", 64'(mem_oen), 64'd1);
        chk("wen_single_cycle", 64'(wen_prev), 64'd1);
      end
      tb_ram[mem_addr] = mem_data;
    end
    wen_prev = mem_wen;
  end

  task automatic reset_check(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_cen"}, 64'(mem_cen), 64'd1);
    chk({tag, "_wen"}, 64'(mem_wen), 64'd1);
    chk({tag, "_oen"}, 64'(mem_oen), 64'd1);
    chk({tag, "_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_data"}, 64'(mem_data), 64'd0);
    chk({tag, "_cpu_reset_n"}, 64'(cpu_reset_n), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_error"}, 64'(error), 64'd0);
    chk({tag, "_word_count"}, 64'(word_count), 64'd0);
  endtask

  // Begin a load; the state seen right after the start edge is checked.
  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    ref_count = 0;
    ref_done  = 1'b0;
    chk("start_cpu_reset_n", 64'(cpu_reset_n), 64'd0);
    chk("start_word_count", 64'(word_count), 64'd0);
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_done", 64'(done), 64'd0);
    chk("start_in_ready", 64'(in_ready), 64'd1);
  endtask

  // Offer one byte with random idle gaps; returns just after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int pct);
    int guard;
    while (int'($urandom_range(99)) >= pct) begin
      in_valid = 1'b0;
      in_byte  = 8'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_byte  = b;
    guard    = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        break;
      end
      guard++;
      if (guard > 50) begin
        total++;
        bad++;
        $display("FAIL byte_timeout: in_ready stayed 0, expected 1 within 50 cycles");
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  // Reference model: word k of a load lands at address k.
  task automatic send_word(input logic [31:0] w, input int pct);
    for (int i = 0; i < 4; i++) send_byte(w[(31 - 8 * i) -: 8], pct);
    exp_q.push_back({11'(ref_count), w});
    ref_ram[ref_count] = w;
    ref_count++;
    if (w == HALT) ref_done = 1'b1;
  endtask

  task automatic load(input logic [31:0] img[$], input int pct, input int glitch_at);
    for (int k = 0; k < img.size(); k++) begin
      if (k == glitch_at) begin
        chk("busy_at_glitch", 64'(busy), 64'd1);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("count_after_glitch", 64'(word_count), 64'(ref_count));
      end
      send_word(img[k], pct);
      if (ref_done || ref_count == 2048) break;
    end
  endtask

  task automatic finish_check(input string tag);
    int n;
    n = 0;
    while (!(done || error)) begin
      @(posedge clk);
      #1;
      n++;
      if (n > 20) begin
        total++;
        bad++;
        $display("FAIL %s_end_timeout: done/error still 0, expected one set within 20 cycles", tag);
        break;
      end
    end
    chk({tag, "_done"}, 64'(done), 64'(ref_done));
    chk({tag, "_error"}, 64'(error), 64'(!ref_done));
    chk({tag, "_cpu_reset_n"}, 64'(cpu_reset_n), 64'(ref_done));
    chk({tag, "_word_count"}, 64'(word_count), 64'(ref_count));
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < ref_count; i++) chk({tag, "_ram"}, 64'(tb_ram[i]), 64'(ref_ram[i]));
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w == HALT) w = 32'h0;
    return w;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] img[$];
    int n;
    for (int i = 0; i < 2048; i++) begin
      ref_ram[i] = 32'h0;
      tb_ram[i]  = 32'h0;
    end
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_byte  = 8'h00;
    #12;
    reset_check("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed image from the bring-up sequence.
    do_start();
    img = '{32'h0000_0011, 32'h2233_4455, HALT};
    load(img, 100, -1);
    finish_check("basic");

    // Same image with ~50% valid, restarted from DONE, with an ignored mid-load start.
    for (int i = 0; i < 3; i++) tb_ram[i] = 32'h0;
    do_start();
    load(img, 50, 1);
    finish_check("toggle");

    // Random image overwriting from address 0.
    img = {};
    for (int i = 0; i < 5; i++) img.push_back(rand_word());
    img.push_back(HALT);
    do_start();
    load(img, int'($urandom_range(30, 100)), 3);
    finish_check("random");

    // Asynchronous reset after two bytes of a word; partial bytes must be dropped.
    do_start();
    send_byte(8'hA5, 100);
    send_byte(8'h5A, 100);
    #2;
    rst = 1'b1;
    #1;
    reset_check("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    do_start();
    img = '{32'h1234_5678, HALT};
    load(img, 70, -1);
    finish_check("after_rst");

    // HALT-only image with in_valid held high from the start cycle.
    start    = 1'b1;
    in_valid = 1'b1;
    in_byte  = 8'hFF;
    exp_q.push_back({11'd0, HALT});
    ref_ram[0] = HALT;
    ref_count  = 1;
    ref_done   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("halt_only_latency", 64'(n), 64'd5);
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    finish_check("halt_only");

    // Full RAM without HALT: error, last write at 2047, extra bytes ignored.
    img = {};
    for (int i = 0; i < 2048; i++) img.push_back(rand_word());
    do_start();
    load(img, 100, -1);
    finish_check("full");
    chk("full_last_addr", 64'(mem_addr), 64'd2047);
    in_valid = 1'b1;
    in_byte  = 8'h77;
    repeat (10) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("error_in_ready", 64'(in_ready), 64'd0);
    chk("error_hold_count", 64'(word_count), 64'd2048);
    chk("error_hold_flag", 64'(error), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
